// File: rtl/dac_spi_serializer.sv
`default_nettype none
// dac_spi_serializer: ships 12-bit samples to a 16-bit-frame SPI DAC (data sampled on SCLK fall).
// Revision: 1.0
module dac_spi_serializer #(
   parameter int unsigned CLK_DIV   = 4,
   parameter logic [3:0]  CTRL_BITS = 4'b0000,
   parameter int unsigned SYNC_GAP  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        dac_sclk,
   output logic        dac_sync_n,
   output logic        dac_din,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
   // The IDLE cycle that presents ready counts as the last sync-high cycle of the gap.
   localparam logic [7:0] c_GAP_LAST = (SYNC_GAP > 1) ? 8'(SYNC_GAP - 2) : 8'd0;
   localparam logic       c_GAP_SKIP = (SYNC_GAP <= 1);
   localparam logic [4:0] c_LAST_BIT = 5'd15;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_div,   w_div_nxt;
   logic [4:0]  r_bit,   w_bit_nxt;
   logic [7:0]  r_gap,   w_gap_nxt;
   logic [15:0] r_shift, w_shift_nxt;
   logic        r_sclk,  w_sclk_nxt;
   logic        r_sync_n, w_sync_n_nxt;
   logic        r_din,   w_din_nxt;
   logic        r_ready, w_ready_nxt;
   logic        r_done,  w_done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_div    <= 8'd0;
         r_bit    <= 5'd0;
         r_gap    <= 8'd0;
         r_shift  <= 16'd0;
         r_sclk   <= 1'b1;
         r_sync_n <= 1'b1;
         r_din    <= 1'b0;
         r_ready  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_div    <= w_div_nxt;
         r_bit    <= w_bit_nxt;
         r_gap    <= w_gap_nxt;
         r_shift  <= w_shift_nxt;
         r_sclk   <= w_sclk_nxt;
         r_sync_n <= w_sync_n_nxt;
         r_din    <= w_din_nxt;
         r_ready  <= w_ready_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_div_nxt    = r_div;
      w_bit_nxt    = r_bit;
      w_gap_nxt    = r_gap;
      w_shift_nxt  = r_shift;
      w_sclk_nxt   = r_sclk;
      w_sync_n_nxt = r_sync_n;
      w_din_nxt    = r_din;
      w_ready_nxt  = r_ready;
      w_done_nxt   = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_sclk_nxt   = 1'b1;
            w_sync_n_nxt = 1'b1;
            w_ready_nxt  = 1'b1;
            if (sample_valid && r_ready) begin
               w_shift_nxt  = {CTRL_BITS, sample_in};
               w_din_nxt    = CTRL_BITS[3];
               w_sync_n_nxt = 1'b0;
               w_ready_nxt  = 1'b0;
               w_div_nxt    = 8'd0;
               w_bit_nxt    = 5'd0;
               w_state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            if (r_div == c_DIV_LAST) begin
               w_div_nxt  = 8'd0;
               w_sclk_nxt = ~r_sclk;
               // Rising edge: advance to the next bit, or close the frame after bit 15.
               if (!r_sclk) begin
                  if (r_bit == c_LAST_BIT) begin
                     w_sync_n_nxt = 1'b1;
                     w_done_nxt   = 1'b1;
                     w_din_nxt    = 1'b0;
                     w_gap_nxt    = 8'd0;
                     w_ready_nxt  = c_GAP_SKIP;
                     w_state_nxt  = c_GAP_SKIP ? IDLE : GAP;
                  end else begin
                     w_din_nxt   = r_shift[14];
                     w_shift_nxt = {r_shift[14:0], 1'b0};
                     w_bit_nxt   = r_bit + 5'd1;
                  end
               end
            end else begin
               w_div_nxt = r_div + 8'd1;
            end
         end
         GAP: begin
            if (r_gap == c_GAP_LAST) begin
               w_ready_nxt = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap + 8'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign sample_ready = r_ready;
   assign dac_sclk     = r_sclk;
   assign dac_sync_n   = r_sync_n;
   assign dac_din      = r_din;
   assign frame_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_serializer.sv
`default_nettype none
// tb_dac_spi_serializer: directed checks of frame content, timing, handshake and reset abort.
// Revision: 1.0
module tb_dac_spi_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] a_sample = 12'd0, b_sample = 12'd0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, a_sclk, a_sync_n, a_din, a_done;
   logic        b_ready, b_sclk, b_sync_n, b_din, b_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dac_spi_serializer #(.CLK_DIV(4), .CTRL_BITS(4'b0000), .SYNC_GAP(2)) u_dut_a (
      .clk(clk), .rst(rst), .sample_in(a_sample), .sample_valid(a_valid),
      .sample_ready(a_ready), .dac_sclk(a_sclk), .dac_sync_n(a_sync_n),
      .dac_din(a_din), .frame_done(a_done)
   );

   dac_spi_serializer #(.CLK_DIV(1), .CTRL_BITS(4'b0011), .SYNC_GAP(2)) u_dut_b (
      .clk(clk), .rst(rst), .sample_in(b_sample), .sample_valid(b_valid),
      .sample_ready(b_ready), .dac_sclk(b_sclk), .dac_sync_n(b_sync_n),
      .dac_din(b_din), .frame_done(b_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input int which, input logic [11:0] s);
      if (which == 0) begin a_sample = s; a_valid = 1'b1; end
      else            begin b_sample = s; b_valid = 1'b1; end
   endtask

   // Observe ncyc cycles after the transfer edge (index 0 = cycle after T0).
   // mode 0: drop valid; mode 1: keep valid, present nxt; mode 2: scramble sample, stray valid pulses.
   task automatic run_frame(input int which, input int ncyc, input int cdiv, input int mode,
                            input logic [11:0] nxt, output logic [15:0] word,
                            output int sync_low, output int done_idx, output int done_cnt,
                            output int falls, output int viol, output int rdy_first,
                            output int rdy_cnt);
      logic prev_sclk, prev_din, sclk, sync, din, done, rdy;
      int   last_fall, last_chg;
      word = 16'd0; sync_low = 0; done_idx = -1; done_cnt = 0; falls = 0; viol = 0;
      rdy_first = -1; rdy_cnt = 0;
      prev_sclk = 1'b1; prev_din = 1'b0; last_fall = -1000; last_chg = -1000;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (which == 0) {sclk, sync, din, done, rdy} = {a_sclk, a_sync_n, a_din, a_done, a_ready};
         else            {sclk, sync, din, done, rdy} = {b_sclk, b_sync_n, b_din, b_done, b_ready};
         if (din !== prev_din) begin
            if (i - last_fall < cdiv) viol++;
            last_chg = i;
         end
         if (prev_sclk && !sclk) begin
            if (i - last_chg < cdiv) viol++;
            last_fall = i;
            falls++;
            word = {word[14:0], din};
         end
         if (sync && !sclk) viol++;
         if (!sync) sync_low++;
         if (done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
         if (rdy) begin
            rdy_cnt++;
            if (rdy_first < 0) rdy_first = i;
         end
         prev_sclk = sclk;
         prev_din  = din;
         case (mode)
            0: if (i == 0) begin
                  if (which == 0) a_valid = 1'b0; else b_valid = 1'b0;
               end
            1: if (i == 0) begin
                  if (which == 0) a_sample = nxt; else b_sample = nxt;
               end
            default: begin
               a_sample = 12'($urandom);
               a_valid  = ((i % 7) == 3) && (i < 100);
            end
         endcase
      end
   endtask

   logic [15:0] w;
   logic [11:0] s;
   int sl, di, dc, fl, vi, rf, rc;

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(a_ready), 32'd0);
      check("rst_sclk", 32'(a_sclk), 32'd1);
      check("rst_sync", 32'(a_sync_n), 32'd1);
      check("rst_din", 32'(a_din), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(a_ready), 32'd1);

      // Single frame 0xA5C
      start(0, 12'hA5C);
      run_frame(0, 140, 4, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
      check("t1_word", 32'(w), 32'h0A5C);
      check("t1_sync_low", 32'(sl), 32'd128);
      check("t1_done_idx", 32'(di), 32'd128);
      check("t1_done_cnt", 32'(dc), 32'd1);
      check("t1_falls", 32'(fl), 32'd16);
      check("t1_viol", 32'(vi), 32'd0);
      check("t1_ready_idx", 32'(rf), 32'd129);

      // Back-to-back 0x000 then 0xFFF with valid held
      start(0, 12'h000);
      run_frame(0, 130, 4, 1, 12'hFFF, w, sl, di, dc, fl, vi, rf, rc);
      check("t2a_word", 32'(w), 32'h0000);
      check("t2a_ready_cnt", 32'(rc), 32'd1);
      check("t2a_ready_idx", 32'(rf), 32'd129);
      run_frame(0, 131, 4, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
      check("t2b_word", 32'(w), 32'h0FFF);
      check("t2b_sync_low", 32'(sl), 32'd128);
      check("t2b_done_idx", 32'(di), 32'd128);
      check("t2b_viol", 32'(vi), 32'd0);

      // Input changes and stray valid pulses during a frame
      start(0, 12'h123);
      run_frame(0, 200, 4, 2, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
      check("t3_word", 32'(w), 32'h0123);
      check("t3_sync_low", 32'(sl), 32'd128);
      check("t3_done_cnt", 32'(dc), 32'd1);
      check("t3_falls", 32'(fl), 32'd16);
      a_valid = 1'b0;

      // Reset mid-frame, then a clean 0x7FF frame
      start(0, 12'h3C3);
      run_frame(0, 50, 4, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
      check("t4_sync_before", 32'(a_sync_n), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("t4_sclk", 32'(a_sclk), 32'd1);
      check("t4_sync", 32'(a_sync_n), 32'd1);
      check("t4_din", 32'(a_din), 32'd0);
      check("t4_done", 32'(a_done), 32'd0);
      check("t4_ready_in_rst", 32'(a_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("t4_ready_after", 32'(a_ready), 32'd1);
      start(0, 12'h7FF);
      run_frame(0, 131, 4, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
      check("t4_word", 32'(w), 32'h07FF);
      check("t4_done_idx", 32'(di), 32'd128);
      check("t4_viol", 32'(vi), 32'd0);

      // CLK_DIV=1, CTRL_BITS=0011
      start(1, 12'h800);
      run_frame(1, 40, 1, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
      check("t5_word", 32'(w), 32'h3800);
      check("t5_sync_low", 32'(sl), 32'd32);
      check("t5_done_idx", 32'(di), 32'd32);
      check("t5_ready_idx", 32'(rf), 32'd33);
      check("t5_falls", 32'(fl), 32'd16);
      check("t5_viol", 32'(vi), 32'd0);

      // Random samples with protocol checks on both instances
      for (int k = 0; k < 3; k++) begin
         s = 12'($urandom);
         start(0, s);
         run_frame(0, 131, 4, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
         check("t6a_word", 32'(w), {20'd0, s});
         check("t6a_falls", 32'(fl), 32'd16);
         check("t6a_viol", 32'(vi), 32'd0);
         s = 12'($urandom);
         start(1, s);
         run_frame(1, 35, 1, 0, 12'h0, w, sl, di, dc, fl, vi, rf, rc);
         check("t6b_word", 32'(w), {16'd0, 4'b0011, s});
         check("t6b_sync_low", 32'(sl), 32'd32);
         check("t6b_viol", 32'(vi), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
